// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag and FSM types shared by the pipelined ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_NOT  = 4'd2,
        OP_NAND = 4'd3,
        OP_NOR  = 4'd4,
        OP_AND  = 4'd5,
        OP_XOR  = 4'd6,
        OP_OR   = 4'd7,
        OP_XNOR = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic neg;
        logic zero;
        logic carry;
        logic ovf;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add unsigned multiplier, one partial product per cycle
// The start cycle already performs the first step, so WIDTH steps finish WIDTH-1 cycles later.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] prod_q, step_in, step_out;
    logic [WIDTH-1:0]   mcand_q, step_m;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH:0]   shifted;

    // Product register holds {partial high, remaining multiplier bits}; shift right each step.
    always_comb begin
        step_in  = start_i ? {{WIDTH{1'b0}}, b_i} : prod_q;
        step_m   = start_i ? a_i : mcand_q;
        hi_sum   = {1'b0, step_in[2*WIDTH-1:WIDTH]} + (step_in[0] ? {1'b0, step_m} : '0);
        shifted  = {hi_sum, step_in[WIDTH-1:0]};
        step_out = shifted[2*WIDTH:1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            prod_q  <= step_out;
            mcand_q <= a_i;
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            prod_q <= step_out;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q & (cnt_q == CW'(1));
    assign product_o = prod_q;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU with flags; ALU_PIPE_MUL_EN adds a sequential multiplier
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    alu_op_e          s1_op_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q, out_res_d, alu_res;
    alu_flags_t       flags_q, out_flags_d, alu_flags;
    logic [WIDTH:0]   sum, diff;
    logic             stall, accept, s1_is_mul, load_single, load_mul, load_out;
    logic [2*WIDTH-1:0] mul_product;
    alu_state_e       state_q;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~rst & (state_q == IDLE) & ~s1_is_mul & (~s1_valid_q | ~stall);
    assign accept   = in_valid & in_ready;

`ifdef ALU_PIPE_MUL_EN
    alu_state_e state_d;
    logic       mul_start, mul_busy, mul_done;

    assign s1_is_mul = s1_valid_q & (s1_op_q == OP_MUL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (s1_is_mul) state_d = MUL;
            MUL: begin
                if (mul_done)      state_d = DONE;
                else if (!mul_busy) state_d = IDLE;
            end
            DONE: if (!stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mul_start = (state_q == IDLE) & s1_is_mul;
        load_mul  = (state_q == DONE) & ~stall;
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (s1_a_q),
        .b_i       (s1_b_q),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );
`else
    assign state_q     = IDLE;
    assign s1_is_mul   = 1'b0;
    assign load_mul    = 1'b0;
    assign mul_product = '0;
`endif

    // Single-cycle datapath on the s1 operands; unknown opcodes fall to result 0.
    always_comb begin
        sum       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff      = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        alu_res   = '0;
        alu_flags = '0;
        case (s1_op_q)
            OP_ADD: begin
                alu_res         = sum[WIDTH-1:0];
                alu_flags.carry = sum[WIDTH];
                alu_flags.ovf   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) & (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res       = diff[WIDTH-1:0];
                alu_flags.neg = diff[WIDTH];
                alu_flags.ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) & (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_NOT:  alu_res = ~s1_a_q;
            OP_NAND: alu_res = ~(s1_a_q & s1_b_q);
            OP_NOR:  alu_res = ~(s1_a_q | s1_b_q);
            OP_AND:  alu_res = s1_a_q & s1_b_q;
            OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
            OP_OR:   alu_res = s1_a_q | s1_b_q;
            OP_XNOR: alu_res = ~(s1_a_q ^ s1_b_q);
            OP_SHL:  alu_res = s1_a_q << s1_b_q[SHW-1:0];
            OP_SHR:  alu_res = s1_a_q >> s1_b_q[SHW-1:0];
            default: alu_res = '0;
        endcase
        alu_flags.zero = (alu_res == '0);
    end

    always_comb begin
        out_res_d   = alu_res;
        out_flags_d = alu_flags;
        if (load_mul) begin
            out_res_d         = mul_product[WIDTH-1:0];
            out_flags_d       = '0;
            out_flags_d.carry = |mul_product[2*WIDTH-1:WIDTH];
            out_flags_d.zero  = (mul_product[WIDTH-1:0] == '0);
        end
    end

    assign load_single = (state_q == IDLE) & s1_valid_q & ~s1_is_mul & ~stall;
    assign load_out    = load_single | load_mul;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_ADD;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_a_q     <= a;
            s1_b_q     <= b;
            s1_op_q    <= alu_op_e'(op);
        end else if (load_out) begin
            s1_valid_q <= 1'b0;
        end
    end

    // A retiring beat may be replaced in the same cycle, so load takes priority over retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            result_q    <= out_res_d;
            flags_q     <= out_flags_d;
        end else if (out_valid_q & out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign neg       = flags_q.neg;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and randomized checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;

`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b, result;
    logic [3:0]  op;
    logic        neg, zero, carry, ovf;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, result16;
    logic [3:0]  op16;
    logic        neg16, zero16, carry16, ovf16;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [7:0] r;
        logic n;
        logic z;
        logic c;
        logic v;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .neg(neg), .zero(zero), .carry(carry), .ovf(ovf)
    );

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .op(op16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .neg(neg16), .zero(zero16), .carry(carry16), .ovf(ovf16)
    );

    function automatic exp_t model(input int o, input int x, input int y);
        exp_t e;
        int   r, s, sx, sy;
        e  = '0;
        r  = 0;
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        case (o)
            0: begin
                s   = x + y;
                r   = s % 256;
                e.c = (s >= 256);
                e.v = (sx + sy > 127) || (sx + sy < -128);
            end
            1: begin
                r   = (x - y + 256) % 256;
                e.n = (y > x);
                e.v = (sx - sy > 127) || (sx - sy < -128);
            end
            2:  r = 255 - x;
            3:  r = 255 - (x & y);
            4:  r = 255 - (x | y);
            5:  r = x & y;
            6:  r = x ^ y;
            7:  r = x | y;
            8:  r = 255 - (x ^ y);
            9:  r = (x << (y % 8)) % 256;
            10: r = x >> (y % 8);
            11: if (MUL_EN) begin
                s   = x * y;
                r   = s % 256;
                e.c = (s >= 256);
            end
            default: r = 0;
        endcase
        e.r = 8'(r);
        e.z = (r == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input exp_t e);
        check({tag, " result"}, 32'(result), 32'(e.r));
        check({tag, " flags nzcv"}, 32'({neg, zero, carry, ovf}), 32'({e.n, e.z, e.c, e.v}));
    endtask

    task automatic direct(input string tag, input int o, input int x, input int y, input int exp_lat);
        exp_t e;
        int   lat;
        e = model(o, x, y);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        a         = 8'(x);
        b         = 8'(y);
        op        = 4'(o);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            if (o == 11 && MUL_EN) check({tag, " in_ready busy"}, 32'(in_ready), 32'(0));
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_beat(tag, e);
        @(posedge clk);
        @(negedge clk);
        check({tag, " retire"}, 32'(out_valid), 32'(0));
    endtask

    task automatic stream(input string tag, input int ncyc, input bit logic_only);
        bit         pend;
        bit         stalled;
        logic [11:0] held;
        exp_t       e;
        int         i;
        pend    = 1'b0;
        stalled = 1'b0;
        held    = '0;
        i       = 0;
        while (i < ncyc + 300 && (i < ncyc || pend || exp_q.size() != 0 || out_valid)) begin
            @(posedge clk); #1;
            if (!pend && i < ncyc && $urandom_range(0, 3) != 0) begin
                a    = 8'($urandom);
                b    = 8'($urandom);
                op   = logic_only ? 4'($urandom_range(2, 8)) : 4'($urandom_range(0, 15));
                pend = 1'b1;
            end
            in_valid = pend;
            if (i >= ncyc)      out_ready = 1'b1;
            else if (logic_only) out_ready = (i % 2 == 0);
            else                out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stalled) begin
                check({tag, " stall valid"}, 32'(out_valid), 32'(1));
                check({tag, " stall hold"}, 32'({result, neg, zero, carry, ovf}), 32'(held));
            end
            if (out_valid && out_ready) begin
                check({tag, " beat expected"}, 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_beat(tag, e);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(op), int'(a), int'(b)));
                pend = 1'b0;
            end
            stalled = out_valid && !out_ready;
            held    = {result, neg, zero, carry, ovf};
            i++;
        end
        in_valid = 1'b0;
        check({tag, " drained"}, 32'(exp_q.size()), 32'(0));
        check({tag, " no pending"}, 32'(pend), 32'(0));
    endtask

    initial begin
        int seen;
        int lat;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        op          = '0;
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        a16         = '0;
        b16         = '0;
        op16        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'(0));
        check("reset out_valid", 32'(out_valid), 32'(0));
        check("reset result", 32'(result), 32'(0));
        check("reset flags", 32'({neg, zero, carry, ovf}), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        direct("add f0+20", 0, 8'hF0, 8'h20, 2);
        check("add f0+20 const", 32'({result, carry, ovf}), 32'({8'h10, 1'b1, 1'b0}));
        direct("sub 03-05", 1, 8'h03, 8'h05, 2);
        direct("sub 80-01", 1, 8'h80, 8'h01, 2);
        direct("op13", 13, 8'h5A, 8'hA5, 2);
        direct("shl 81<<9", 9, 8'h81, 8'h09, 2);
        direct("shr", 10, 8'hC4, 8'h03, 2);
        direct("mul 10*11", 11, 8'h10, 8'h11, MUL_EN ? 10 : 2);

`ifdef ALU_PIPE_MUL_EN
        @(posedge clk); #1;
        in_valid = 1'b1;
        a        = 8'h10;
        b        = 8'h11;
        op       = 4'd11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst mid-mul in_ready", 32'(in_ready), 32'(0));
        check("rst mid-mul out_valid", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        check("rst mid-mul no beat", 32'(seen), 32'(0));
        direct("add after rst", 0, 8'h7F, 8'h01, 2);
`endif

        stream("logic", 24, 1'b1);
        stream("random", 300, 1'b0);

        @(posedge clk); #1;
        in_valid16 = 1'b1;
        a16        = 16'hFFFF;
        b16        = 16'h0001;
        op16       = 4'd0;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid16 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("w16 latency", 32'(lat), 32'(2));
        check("w16 result", 32'(result16), 32'(0));
        check("w16 flags nzcv", 32'({neg16, zero16, carry16, ovf16}), 32'(4'b0110));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
